// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        FETCH  = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    localparam int STATS_WIDTH = 32;

endpackage

// File: rtl/fetch_unit_sat_counter.sv
// Saturating up-counter: increments on inc, holds at all-ones, async active-high reset.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives program memory, registers one instruction for decode.
// Optional FETCH_STATS_EN adds saturating handshake (fetch_count) and stall (stall_count) counters.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                       ADDRESS_WIDTH = 12,
    parameter int                       DATA_WIDTH    = 32,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic                     mem_wEn,
    input  logic [DATA_WIDTH-1:0]    mem_dataOut,
    input  logic                     redirect_valid,
    input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
    input  logic                     halt_req,
    output logic [DATA_WIDTH-1:0]    instr,
    output logic [ADDRESS_WIDTH-1:0] instr_pc,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    output logic                     halted
`ifdef FETCH_STATS_EN
    ,
    output logic [STATS_WIDTH-1:0]   fetch_count,
    output logic [STATS_WIDTH-1:0]   stall_count
`endif
);

    fetch_state_t             state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0]    instr_q, instr_d;
    logic [ADDRESS_WIDTH-1:0] instr_pc_q, instr_pc_d;
    logic                     valid_q, valid_d;

    logic accept;
    logic slot_free;

    assign accept    = valid_q & instr_ready;
    assign slot_free = ~valid_q | instr_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            instr_q    <= '0;
            instr_pc_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            valid_q    <= valid_d;
        end
    end

    // NOTE: every always_comb output gets a hold default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        valid_d    = valid_q;

        if (redirect_valid) begin
            // The word read at the old PC and any unaccepted slot word are dropped.
            pc_d    = redirect_pc;
            valid_d = 1'b0;
            state_d = halt_req ? HALTED : FETCH;
        end else begin
            case (state_q)
                BOOT: begin
                    state_d = FETCH;
                    if (accept) valid_d = 1'b0;
                end
                FETCH: begin
                    if (halt_req) begin
                        state_d = HALTED;
                        if (accept) valid_d = 1'b0;
                    end else if (slot_free) begin
                        instr_d    = mem_dataOut;
                        instr_pc_d = pc_q;
                        valid_d    = 1'b1;
                        pc_d       = pc_q + 1'b1;
                    end
                end
                HALTED: begin
                    if (accept) valid_d = 1'b0;
                end
                default: begin
                    state_d = BOOT;
                end
            endcase
        end
    end

    assign mem_addr    = pc_q;
    assign mem_wEn     = 1'b0;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = valid_q;
    assign halted      = (state_q == HALTED);

`ifdef FETCH_STATS_EN
    sat_counter #(.WIDTH(STATS_WIDTH)) u_fetch_count (
        .clk   (clk),
        .rst   (rst),
        .inc   (accept),
        .count (fetch_count)
    );

    sat_counter #(.WIDTH(STATS_WIDTH)) u_stall_count (
        .clk   (clk),
        .rst   (rst),
        .inc   (valid_q & ~instr_ready),
        .count (stall_count)
    );
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic vs. a behavioural model.
module tb_fetch_unit;

    localparam int AW    = 12;
    localparam int DW    = 32;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] mem_addr;
    logic          mem_wEn;
    logic [DW-1:0] mem_dataOut;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic          halt_req;
    logic [DW-1:0] instr;
    logic [AW-1:0] instr_pc;
    logic          instr_valid;
    logic          instr_ready;
    logic          halted;
`ifdef FETCH_STATS_EN
    logic [31:0]   fetch_count;
    logic [31:0]   stall_count;
`endif

    logic          sc_rst;
    logic          sc_inc;
    logic [3:0]    sc_count;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fetch_unit #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .RESET_PC('0)) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_addr       (mem_addr),
        .mem_wEn        (mem_wEn),
        .mem_dataOut    (mem_dataOut),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt_req       (halt_req),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .halted         (halted)
`ifdef FETCH_STATS_EN
        ,
        .fetch_count    (fetch_count),
        .stall_count    (stall_count)
`endif
    );

    sat_counter #(.WIDTH(4)) u_sc (
        .clk   (clk),
        .rst   (sc_rst),
        .inc   (sc_inc),
        .count (sc_count)
    );

    // Program memory model: combinational address, word captured on the falling edge.
    logic [DW-1:0] mem [DEPTH];
    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'h1000_0000 + i;
    end
    always @(negedge clk) mem_dataOut <= mem[mem_addr];

    // Behavioural reference: what decode should see, tracked from the stage's rules.
    int          m_pc;
    bit          m_booting;
    bit          m_halted;
    bit          m_valid;
    logic [31:0] m_instr;
    int          m_instr_pc;
    longint      m_fetches;
    longint      m_stalls;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_pc = 0; m_booting = 1; m_halted = 0; m_valid = 0;
        m_instr = '0; m_instr_pc = 0; m_fetches = 0; m_stalls = 0;
    endfunction

    function automatic void model_edge();
        bit taken = m_valid && instr_ready;
        if (m_valid && instr_ready && m_fetches < 64'hFFFF_FFFF) m_fetches++;
        if (m_valid && !instr_ready && m_stalls < 64'hFFFF_FFFF) m_stalls++;
        if (redirect_valid) begin
            m_pc = redirect_pc; m_valid = 0; m_booting = 0; m_halted = halt_req;
        end else if (m_booting) begin
            m_booting = 0;
            if (taken) m_valid = 0;
        end else if (m_halted) begin
            if (taken) m_valid = 0;
        end else if (halt_req) begin
            m_halted = 1;
            if (taken) m_valid = 0;
        end else if (!m_valid || instr_ready) begin
            m_instr = mem[m_pc]; m_instr_pc = m_pc; m_valid = 1;
            m_pc = (m_pc + 1) % DEPTH;
        end
    endfunction

    task automatic compare_all();
        check("mem_addr", 64'(mem_addr), 64'(m_pc));
        check("mem_wEn", 64'(mem_wEn), 64'(0));
        check("instr_valid", 64'(instr_valid), 64'(m_valid));
        check("instr", 64'(instr), 64'(m_instr));
        check("instr_pc", 64'(instr_pc), 64'(m_instr_pc));
        check("halted", 64'(halted), 64'(m_halted));
`ifdef FETCH_STATS_EN
        check("fetch_count", 64'(fetch_count), 64'(m_fetches));
        check("stall_count", 64'(stall_count), 64'(m_stalls));
`endif
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic drive(input bit rv, input int rpc, input bit hr, input bit rdy);
        redirect_valid = rv; redirect_pc = AW'(rpc); halt_req = hr; instr_ready = rdy;
    endtask

    task automatic run_until_pc(input int target);
        int n = 0;
        drive(0, 0, 0, 1);
        while (!(m_valid && m_instr_pc == target) && n < 64) begin
            step();
            n++;
        end
        check("reach_pc_timeout", 64'(n < 64), 64'(1));
    endtask

    initial begin
        rst = 1'b1; sc_rst = 1'b1; sc_inc = 1'b0;
        drive(0, 0, 0, 1);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        rst = 1'b0; sc_rst = 1'b0;

        // Reset release: BOOT edge, then first instruction on the second edge.
        step();
        check("boot_no_valid", 64'(instr_valid), 64'(0));
        step();
        check("first_instr", 64'(instr), 64'h1000_0000);
        check("first_pc", 64'(instr_pc), 64'(0));
        repeat (3) step();
        check("seq_pc3", 64'(instr_pc), 64'(3));

        // Back-pressure at pc 5.
        run_until_pc(5);
        drive(0, 0, 0, 0);
        repeat (3) begin
            step();
            check("bp_pc_hold", 64'(instr_pc), 64'(5));
            check("bp_addr_hold", 64'(mem_addr), 64'(6));
        end
        drive(0, 0, 0, 1);
        step();
        check("bp_release", 64'(instr_pc), 64'(6));

        // Redirect while slot holds pc 7 unaccepted.
        run_until_pc(7);
        drive(1, 'h200, 0, 0);
        step();
        check("redir_flush", 64'(instr_valid), 64'(0));
        drive(0, 0, 0, 1);
        step();
        check("redir_target", 64'(instr_pc), 64'h200);

        // Wrap at the top of the address space.
        drive(1, 'hFFE, 0, 1);
        step();
        drive(0, 0, 0, 1);
        repeat (3) step();
        check("wrap_pc", 64'(instr_pc), 64'(0));

        // Halt with an occupied slot, drain, resume, then redirect+halt.
        drive(1, 10, 0, 1);
        step();
        drive(0, 0, 0, 0);
        step();
        drive(0, 0, 1, 0);
        step();
        drive(0, 0, 0, 0);
        step();
        check("halt_slot_kept", 64'(instr_valid), 64'(1));
        drive(0, 0, 0, 1);
        repeat (4) step();
        check("halted_flag", 64'(halted), 64'(1));
        check("halted_no_valid", 64'(instr_valid), 64'(0));
        drive(1, 'h20, 0, 1);
        step();
        drive(0, 0, 0, 1);
        step();
        check("resume_pc", 64'(instr_pc), 64'h20);
        drive(1, 'h300, 1, 1);
        step();
        drive(0, 0, 0, 1);
        repeat (3) step();
        check("redir_halt_addr", 64'(mem_addr), 64'h300);
        check("redir_halt_stay", 64'(halted), 64'(1));

        // Randomized traffic with an asynchronous reset in the middle.
        for (int c = 0; c < 3000; c++) begin
            drive(($urandom_range(99) < 5), $urandom_range(DEPTH - 1),
                  ($urandom_range(99) < 3), ($urandom_range(99) < 75));
            if (c == 1500) begin
                #2;
                rst = 1'b1;
                #1;
                model_reset();
                compare_all();
                rst = 1'b0;
            end
            step();
        end

        // Saturation on a narrow counter instance.
        drive(0, 0, 0, 1);
        sc_inc = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            check("sat_count", 64'(sc_count), 64'((i > 15) ? 15 : i));
        end
        sc_inc = 1'b0;
        sc_rst = 1'b1;
        #1;
        check("sat_reset", 64'(sc_count), 64'(0));
        sc_rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
